// File: rtl/axi_interconnect_fifogen_gray2dec_if.sv
// Pointer bus for the Gray-to-binary converter: Gray word in, binary word out,
// each with its own qualifier.
interface axi_interconnect_fifogen_gray2dec_if #(
   parameter int DW = 16
) ();
   logic          ivalid;
   logic [DW-1:0] idata;
   logic          ovalid;
   logic [DW-1:0] odata;

   modport master (output ivalid, output idata, input ovalid, input odata);
   modport slave  (input ivalid, input idata, output ovalid, output odata);
endinterface

// File: rtl/axi_interconnect_fifogen_gray2dec.sv
// Pipelined Gray-to-binary pointer decoder: the prefix-XOR chain is cut MSB-first
// into PIPE_STAGES register stages, each resolving one segment of bits.
module axi_interconnect_fifogen_gray2dec #(
   parameter int PIPE_STAGES = 2,
   parameter int DW          = 16,
   parameter int U_DLY       = 1
) (
   input  logic                                clk_sys,
   input  logic                                rst,
   input  logic                                ce,
   axi_interconnect_fifogen_gray2dec_if.slave  bus
);

   // U_DLY only matters to delay-annotated simulation models; no delay is applied here.
   localparam int UNUSED_U_DLY = U_DLY;

   // Segment width; shrunk when ceil(DW/PIPE_STAGES) would leave trailing stages without bits.
   function automatic int calc_seg(input int dw, input int ps);
      int s;
      if (ps < 1) return dw;
      s = (dw + ps - 1) / ps;
      while (s > 1 && (ps - 1) * s >= dw) s--;
      return s;
   endfunction

   localparam int SEG = calc_seg(DW, PIPE_STAGES);

   generate
      if (PIPE_STAGES == 0) begin : g_comb
         logic          comb_run;
         logic [DW-1:0] comb_bin;
         logic          unused_ctrl;

         always_comb begin
            comb_run = 1'b0;
            comb_bin = '0;
            for (int i = DW - 1; i >= 0; i--) begin
               comb_run    = comb_run ^ bus.idata[i];
               comb_bin[i] = comb_run;
            end
         end

         assign bus.odata   = comb_bin;
         assign bus.ovalid  = bus.ivalid;
         assign unused_ctrl = clk_sys ^ rst ^ ce;
      end else begin : g_pipe
         for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            localparam int HI = DW - 1 - gi * SEG;
            localparam int LO = (gi == PIPE_STAGES - 1) ? 0 : DW - (gi + 1) * SEG;

            logic [DW-1:0] din;
            logic          vin;
            logic          cin;
            logic          run;
            logic [DW-1:0] conv;
            logic [DW-1:0] data_d;
            logic [DW-1:0] data_q;
            logic          valid_d;
            logic          valid_q;

            // Word layout per stage: resolved binary above HI, raw Gray at and below it.
            if (gi == 0) begin : g_first
               assign din = bus.idata;
               assign vin = bus.ivalid;
               assign cin = 1'b0;
            end else begin : g_next
               assign din = g_stage[gi-1].data_q;
               assign vin = g_stage[gi-1].valid_q;
               assign cin = g_stage[gi-1].data_q[HI+1];
            end

            always_comb begin
               conv = din;
               run  = cin;
               for (int i = DW - 1; i >= 0; i--) begin
                  if (i <= HI && i >= LO) begin
                     run     = run ^ din[i];
                     conv[i] = run;
                  end
               end
               data_d  = data_q;
               valid_d = valid_q;
               // Data only moves with a valid word so odata holds across bubbles.
               if (ce) begin
                  valid_d = vin;
                  if (vin) data_d = conv;
               end
            end

            always_ff @(posedge clk_sys) begin
               if (rst) begin
                  data_q  <= '0;
                  valid_q <= 1'b0;
               end else begin
                  data_q  <= data_d;
                  valid_q <= valid_d;
               end
            end
         end

         assign bus.odata  = g_stage[PIPE_STAGES-1].data_q;
         assign bus.ovalid = g_stage[PIPE_STAGES-1].valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_axi_interconnect_fifogen_gray2dec.sv
// Drives five decoder configurations with one stimulus stream and checks each
// against a delay-line model fed by binary counters encoded to Gray.
module tb_axi_interconnect_fifogen_gray2dec;

   localparam int NDUT = 5;
   localparam int PS [NDUT] = '{2, 0, 1, 3, 16};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic        ivalid = 1'b0;
   logic [15:0] bin = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic        act_v [NDUT];
   logic [15:0] act_d [NDUT];
   logic        exp_v [NDUT];
   logic [15:0] exp_d [NDUT];
   logic        mq_v  [NDUT][16];
   logic [15:0] mq_d  [NDUT][16];

   always #5 clk = ~clk;

   axi_interconnect_fifogen_gray2dec_if #(.DW(4))  b0 ();
   axi_interconnect_fifogen_gray2dec_if #(.DW(16)) b1 ();
   axi_interconnect_fifogen_gray2dec_if #(.DW(16)) b2 ();
   axi_interconnect_fifogen_gray2dec_if #(.DW(16)) b3 ();
   axi_interconnect_fifogen_gray2dec_if #(.DW(16)) b4 ();

   assign b0.idata  = bin[3:0] ^ (bin[3:0] >> 1);
   assign b1.idata  = bin ^ (bin >> 1);
   assign b2.idata  = bin ^ (bin >> 1);
   assign b3.idata  = bin ^ (bin >> 1);
   assign b4.idata  = bin ^ (bin >> 1);
   assign b0.ivalid = ivalid;
   assign b1.ivalid = ivalid;
   assign b2.ivalid = ivalid;
   assign b3.ivalid = ivalid;
   assign b4.ivalid = ivalid;

   assign act_v[0] = b0.ovalid;  assign act_d[0] = {12'h000, b0.odata};
   assign act_v[1] = b1.ovalid;  assign act_d[1] = b1.odata;
   assign act_v[2] = b2.ovalid;  assign act_d[2] = b2.odata;
   assign act_v[3] = b3.ovalid;  assign act_d[3] = b3.odata;
   assign act_v[4] = b4.ovalid;  assign act_d[4] = b4.odata;

   axi_interconnect_fifogen_gray2dec #(.PIPE_STAGES(2),  .DW(4))  u_d0 (.clk_sys(clk), .rst(rst), .ce(ce), .bus(b0));
   axi_interconnect_fifogen_gray2dec #(.PIPE_STAGES(0),  .DW(16)) u_d1 (.clk_sys(clk), .rst(rst), .ce(ce), .bus(b1));
   axi_interconnect_fifogen_gray2dec #(.PIPE_STAGES(1),  .DW(16)) u_d2 (.clk_sys(clk), .rst(rst), .ce(ce), .bus(b2));
   axi_interconnect_fifogen_gray2dec #(.PIPE_STAGES(3),  .DW(16)) u_d3 (.clk_sys(clk), .rst(rst), .ce(ce), .bus(b3));
   axi_interconnect_fifogen_gray2dec #(.PIPE_STAGES(16), .DW(16)) u_d4 (.clk_sys(clk), .rst(rst), .ce(ce), .bus(b4));

   // One clock: apply inputs, let the model advance on the edge, settle 1 time unit.
   task automatic step(input logic c, input logic r, input logic v, input logic [15:0] n);
      logic [15:0] nm;
      int p;
      ce = c; rst = r; ivalid = v; bin = n;
      @(posedge clk);
      for (int j = 0; j < NDUT; j++) begin
         p  = PS[j];
         nm = (j == 0) ? {12'h000, n[3:0]} : n;
         if (p == 0) begin
            exp_v[j] = v;
            exp_d[j] = nm;
         end else if (r) begin
            for (int k = 0; k < 16; k++) begin
               mq_v[j][k] = 1'b0;
               mq_d[j][k] = '0;
            end
            exp_v[j] = 1'b0;
            exp_d[j] = '0;
         end else if (c) begin
            for (int k = 15; k > 0; k--) begin
               mq_v[j][k] = mq_v[j][k-1];
               mq_d[j][k] = mq_d[j][k-1];
            end
            mq_v[j][0] = v;
            mq_d[j][0] = nm;
            exp_v[j]   = mq_v[j][p-1];
            if (exp_v[j]) exp_d[j] = mq_d[j][p-1];
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b1, 1'b1, 16'h1234);
      for (int j = 0; j < NDUT; j++) begin
         if (PS[j] != 0) begin
            n_checks++;
            if (act_v[j] !== 1'b0 || act_d[j] !== 16'h0000) begin
               n_fail++;
               $display("FAIL reset dut%0d P=%0d: got ovalid=%0b odata=%h, want 0/0000",
                        j, PS[j], act_v[j], act_d[j]);
            end
         end
      end
      $display("reset: outputs cleared");
   endtask

   task automatic test_directed_dw4();
      logic [3:0] want [2] = '{4'b0100, 4'b1111};
      step(1'b1, 1'b0, 1'b1, 16'h0004);
      step(1'b1, 1'b0, 1'b1, 16'h000F);
      for (int t = 0; t < 2; t++) begin
         n_checks++;
         if (b0.ovalid !== 1'b1 || b0.odata !== want[t]) begin
            n_fail++;
            $display("FAIL dw4_word%0d: got ovalid=%0b odata=%b, want 1/%b",
                     t, b0.ovalid, b0.odata, want[t]);
         end
         $display("dw4 word%0d: odata=%b ovalid=%0b", t, b0.odata, b0.ovalid);
         step(1'b1, 1'b0, 1'b0, 16'h0000);
      end
   endtask

   task automatic test_sweep(input logic [15:0] start, input int count);
      logic [15:0] n;
      n = start;
      for (int s = 0; s < count; s++) begin
         step(1'b1, 1'b0, 1'b1, n);
         n = n + 16'd1;
         for (int j = 0; j < NDUT; j++) begin
            n_checks++;
            if (act_v[j] !== exp_v[j] || act_d[j] !== exp_d[j]) begin
               n_fail++;
               $display("FAIL sweep dut%0d P=%0d: got ovalid=%0b odata=%h, want ovalid=%0b odata=%h",
                        j, PS[j], act_v[j], act_d[j], exp_v[j], exp_d[j]);
            end
         end
      end
      $display("sweep from %h: %0d words", start, count);
   endtask

   task automatic test_bubbles();
      logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int s = 0; s < 24; s++) begin
         step(1'b1, 1'b0, (s < 4) ? pat[s] : 1'b0, 16'($urandom));
         for (int j = 0; j < NDUT; j++) begin
            n_checks++;
            if (act_v[j] !== exp_v[j] || act_d[j] !== exp_d[j]) begin
               n_fail++;
               $display("FAIL bubbles dut%0d P=%0d: got ovalid=%0b odata=%h, want ovalid=%0b odata=%h",
                        j, PS[j], act_v[j], act_d[j], exp_v[j], exp_d[j]);
            end
         end
         $display("bubbles step%0d: dut3 ovalid=%0b odata=%h", s, act_v[3], act_d[3]);
      end
   endtask

   task automatic test_stall();
      for (int s = 0; s < 24; s++) begin
         if (s == 0)      step(1'b1, 1'b0, 1'b1, 16'hA5C3);
         else if (s < 3)  step(1'b1, 1'b0, 1'b0, 16'h0000);
         else if (s < 6)  step(1'b0, 1'b0, 1'b1, 16'($urandom));
         else             step(1'b1, 1'b0, 1'b0, 16'h0000);
         for (int j = 0; j < NDUT; j++) begin
            n_checks++;
            if (act_v[j] !== exp_v[j] || act_d[j] !== exp_d[j]) begin
               n_fail++;
               $display("FAIL stall dut%0d P=%0d: got ovalid=%0b odata=%h, want ovalid=%0b odata=%h",
                        j, PS[j], act_v[j], act_d[j], exp_v[j], exp_d[j]);
            end
         end
         $display("stall step%0d: ce=%0b dut4 ovalid=%0b odata=%h", s, ce, act_v[4], act_d[4]);
      end
   endtask

   task automatic test_reset_mid();
      for (int s = 0; s < 24; s++) begin
         if (s < 2)        step(1'b1, 1'b0, 1'b1, 16'(16'h3C00 + s));
         else if (s == 2)  step(1'b1, 1'b1, 1'b1, 16'hBEEF);
         else if (s == 6)  step(1'b1, 1'b0, 1'b1, 16'h0F0F);
         else              step(1'b1, 1'b0, 1'b0, 16'h0000);
         for (int j = 0; j < NDUT; j++) begin
            n_checks++;
            if (act_v[j] !== exp_v[j] || act_d[j] !== exp_d[j]) begin
               n_fail++;
               $display("FAIL reset_mid dut%0d P=%0d: got ovalid=%0b odata=%h, want ovalid=%0b odata=%h",
                        j, PS[j], act_v[j], act_d[j], exp_v[j], exp_d[j]);
            end
         end
         $display("reset_mid step%0d: rst=%0b dut3 ovalid=%0b odata=%h", s, rst, act_v[3], act_d[3]);
      end
   endtask

   task automatic test_random(input int cycles);
      for (int s = 0; s < cycles; s++) begin
         step(($urandom % 4) != 0, ($urandom % 250) == 0, ($urandom % 10) < 7, 16'($urandom));
         for (int j = 0; j < NDUT; j++) begin
            n_checks++;
            if (act_v[j] !== exp_v[j] || act_d[j] !== exp_d[j]) begin
               n_fail++;
               $display("FAIL random dut%0d P=%0d: got ovalid=%0b odata=%h, want ovalid=%0b odata=%h",
                        j, PS[j], act_v[j], act_d[j], exp_v[j], exp_d[j]);
            end
         end
      end
      $display("random: %0d cycles", cycles);
   endtask

   task automatic test_comb();
      logic [15:0] n;
      logic        v;
      for (int t = 0; t < 8; t++) begin
         n = 16'($urandom);
         v = t[0];
         #2;
         rst = t[1]; ce = t[2]; ivalid = v; bin = n;
         #1;
         n_checks++;
         if (b1.ovalid !== v || b1.odata !== n) begin
            n_fail++;
            $display("FAIL comb%0d: got ovalid=%0b odata=%h, want ovalid=%0b odata=%h",
                     t, b1.ovalid, b1.odata, v, n);
         end
         $display("comb%0d: rst=%0b ce=%0b odata=%h", t, rst, ce, b1.odata);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int j = 0; j < NDUT; j++) begin
         exp_v[j] = 1'b0;
         exp_d[j] = '0;
      end
      test_reset();
      test_directed_dw4();
      test_sweep(16'h0000, 300);
      test_sweep(16'h7F80, 256);
      test_sweep(16'hFF00, 512);
      test_bubbles();
      test_stall();
      test_reset_mid();
      test_random(3000);
      test_comb();
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      test_sweep(16'hFFF0, 40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
